// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

  localparam int LDST_WIDTH_W = 3;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } mem_arb_state_t;

  localparam word_t MEM_ARB_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - datapath fetch/load-store requests and the shared RAM bus
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                    imem_ren;
  word_t                   imem_addr;
  logic                    ihit;
  word_t                   imem_load;

  logic                    dmem_ren;
  logic                    dmem_wen;
  word_t                   dmem_addr;
  logic [LDST_WIDTH_W-1:0] dmem_width;
  word_t                   dmem_store;
  logic                    dhit;
  word_t                   dmem_load;

  logic                    ram_req;
  logic                    ram_we;
  word_t                   ram_addr;
  logic [3:0]              ram_wstrb;
  word_t                   ram_wdata;
  word_t                   ram_rdata;
  logic                    ram_ready;
  logic                    bus_err;

  // master: the arbiter itself; slave: datapath plus RAM side
  modport master (
    input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width, dmem_store,
    input  ram_rdata, ram_ready,
    output ihit, imem_load, dhit, dmem_load,
    output ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata, bus_err
  );

  modport slave (
    output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width, dmem_store,
    output ram_rdata, ram_ready,
    input  ihit, imem_load, dhit, dmem_load,
    input  ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata, bus_err
  );

endinterface

// File: rtl/mem_arbiter_ldst_strobe_gen.sv
// rtl/mem_arbiter_ldst_strobe_gen.sv - byte-lane write strobes from access width and address
module ldst_strobe_gen
  import mem_arbiter_pkg::*;
(
  input  logic [LDST_WIDTH_W-1:0] i_width,
  input  logic [1:0]              i_addr_lo,
  input  logic                    i_we,
  output logic [3:0]              o_strb
);

  logic w_unused_width;
  assign w_unused_width = ^i_width[LDST_WIDTH_W-1:2];

  always_comb begin
    o_strb = 4'b0000;
    if (i_we) begin
      case (i_width[1:0])
        2'b00:   o_strb = 4'b0001 << i_addr_lo;
        2'b01:   o_strb = 4'b0011 << {i_addr_lo[1], 1'b0};
        default: o_strb = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises data and fetch requests onto one RAM port, data first
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  mem_arbiter_if.master io_bus
);

  localparam int WD_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUS_TIMEOUT - 1);

  mem_arb_state_t  r_state;
  word_t           r_addr;
  word_t           r_wdata;
  word_t           r_rsp;
  logic            r_we;
  logic [3:0]      r_strb;
  logic            r_req;
  logic            r_ihit;
  logic            r_dhit;
  logic            r_bus_err;
  logic [WD_W-1:0] r_wd;

  logic            w_dreq;
  logic [3:0]      w_strb;
  logic            w_unused_addr;

  assign w_dreq        = io_bus.dmem_ren | io_bus.dmem_wen;
  assign w_unused_addr = ^io_bus.imem_addr[1:0];

  ldst_strobe_gen u_strobe (
    .i_width   (io_bus.dmem_width),
    .i_addr_lo (io_bus.dmem_addr[1:0]),
    .i_we      (io_bus.dmem_wen),
    .o_strb    (w_strb)
  );

  // RAM outputs come only from capture registers so a dropped request cannot disturb the bus
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rsp     <= '0;
      r_we      <= 1'b0;
      r_strb    <= 4'b0000;
      r_req     <= 1'b0;
      r_ihit    <= 1'b0;
      r_dhit    <= 1'b0;
      r_bus_err <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_ihit    <= 1'b0;
      r_dhit    <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dreq) begin
            r_state <= DACC;
            r_req   <= 1'b1;
            r_addr  <= {io_bus.dmem_addr[31:2], 2'b00};
            r_we    <= io_bus.dmem_wen;
            r_strb  <= w_strb;
            r_wdata <= io_bus.dmem_wen ? io_bus.dmem_store : '0;
            r_wd    <= '0;
          end else if (io_bus.imem_ren) begin
            r_state <= IACC;
            r_req   <= 1'b1;
            r_addr  <= {io_bus.imem_addr[31:2], 2'b00};
            r_we    <= 1'b0;
            r_strb  <= 4'b0000;
            r_wdata <= '0;
            r_wd    <= '0;
          end
        end
        DACC, IACC: begin
          if (io_bus.ram_ready) begin
            r_rsp   <= io_bus.ram_rdata;
            r_req   <= 1'b0;
            r_dhit  <= (r_state == DACC);
            r_ihit  <= (r_state == IACC);
            r_state <= RESP;
          end else if (r_wd == WD_LAST) begin
            r_rsp     <= MEM_ARB_ERR_WORD;
            r_req     <= 1'b0;
            r_dhit    <= (r_state == DACC);
            r_ihit    <= (r_state == IACC);
            r_bus_err <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.ram_req   = r_req;
  assign io_bus.ram_we    = r_we;
  assign io_bus.ram_addr  = r_addr;
  assign io_bus.ram_wstrb = r_strb;
  assign io_bus.ram_wdata = r_wdata;
  assign io_bus.ihit      = r_ihit;
  assign io_bus.dhit      = r_dhit;
  assign io_bus.imem_load = r_rsp;
  assign io_bus.dmem_load = r_rsp;
  assign io_bus.bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a queue/array reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 4;

  typedef struct {
    word_t      addr;
    logic       we;
    logic [3:0] strb;
    word_t      wdata;
  } bus_exp_t;

  typedef struct {
    bit    is_data;
    bit    chk;
    word_t data;
    bit    err;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic nrst;
  int   n_pass = 0;
  int   n_total = 0;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int       lat_q[$];
  word_t    ref_mem[int unsigned];
  word_t    ram_mem[int unsigned];

  mem_arbiter_if bus();

  mem_arbiter #(.BUS_TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic word_t ref_rd(input word_t widx);
    if (!ref_mem.exists(widx)) ref_mem[widx] = init_word(widx);
    return ref_mem[widx];
  endfunction

  function automatic word_t ram_rd(input word_t widx);
    if (!ram_mem.exists(widx)) ram_mem[widx] = init_word(widx);
    return ram_mem[widx];
  endfunction

  function automatic word_t merge(input word_t old, input word_t nw, input logic [3:0] st);
    word_t r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Natural alignment: an access of nb bytes covers the nb-aligned group holding the address
  function automatic logic [3:0] exp_strb(input logic we, input logic [2:0] w, input logic [1:0] a);
    int nb;
    int base;
    if (!we) return 4'b0000;
    nb   = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
    base = (int'(a) / nb) * nb;
    return 4'(((1 << nb) - 1) << base);
  endfunction

  function automatic int eff_lat(input int l);
    return (l >= TO) ? TO - 1 : l;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ram_req"},   32'(bus.ram_req),   32'd0);
    chk({tag, "_ram_we"},    32'(bus.ram_we),    32'd0);
    chk({tag, "_ram_addr"},  bus.ram_addr,       32'd0);
    chk({tag, "_ram_wstrb"}, 32'(bus.ram_wstrb), 32'd0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata,      32'd0);
    chk({tag, "_ihit"},      32'(bus.ihit),      32'd0);
    chk({tag, "_dhit"},      32'(bus.dhit),      32'd0);
    chk({tag, "_imem_load"}, bus.imem_load,      32'd0);
    chk({tag, "_dmem_load"}, bus.dmem_load,      32'd0);
    chk({tag, "_bus_err"},   32'(bus.bus_err),   32'd0);
  endtask

  task automatic do_txn(input bit want_d, input bit d_we, input bit d_re, input word_t daddr,
                        input logic [2:0] dw, input word_t dst, input int dl, input bit drop_d,
                        input bit want_i, input word_t iaddr, input int il);
    bus_exp_t be;
    rsp_exp_t re;
    int cyc, d_at, i_at, d_exp;
    if (want_d) begin
      be.addr  = {daddr[31:2], 2'b00};
      be.we    = d_we;
      be.strb  = exp_strb(d_we, dw, daddr[1:0]);
      be.wdata = dst;
      bus_q.push_back(be);
      lat_q.push_back(dl);
      re.is_data = 1'b1;
      re.err     = (dl >= TO);
      re.chk     = re.err || !d_we;
      re.data    = re.err ? 32'hDEAD_BEEF : ref_rd(daddr >> 2);
      if (d_we && !re.err) ref_mem[daddr >> 2] = merge(ref_rd(daddr >> 2), dst, be.strb);
      rsp_q.push_back(re);
    end
    if (want_i) begin
      be.addr  = {iaddr[31:2], 2'b00};
      be.we    = 1'b0;
      be.strb  = 4'b0000;
      be.wdata = '0;
      bus_q.push_back(be);
      lat_q.push_back(il);
      re.is_data = 1'b0;
      re.err     = (il >= TO);
      re.chk     = 1'b1;
      re.data    = re.err ? 32'hDEAD_BEEF : ref_rd(iaddr >> 2);
      rsp_q.push_back(re);
    end

    @(negedge clk);
    bus.dmem_ren   = want_d & d_re;
    bus.dmem_wen   = want_d & d_we;
    bus.dmem_addr  = daddr;
    bus.dmem_width = dw;
    bus.dmem_store = dst;
    bus.imem_ren   = want_i;
    bus.imem_addr  = iaddr;
    cyc  = 0;
    d_at = -1;
    i_at = -1;
    while (((want_d && d_at < 0) || (want_i && i_at < 0)) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (drop_d && cyc == 1) begin
        bus.dmem_ren   = 1'b0;
        bus.dmem_wen   = 1'b0;
        bus.dmem_addr  = $urandom;
        bus.dmem_store = $urandom;
        bus.dmem_width = 3'($urandom_range(0, 7));
      end
      if (bus.dhit && d_at < 0) d_at = cyc;
      if (bus.ihit && i_at < 0) i_at = cyc;
      // requests are held across the hit cycle and released after the edge that ends it
      @(posedge clk);
      #1;
      if (d_at == cyc) begin
        bus.dmem_ren = 1'b0;
        bus.dmem_wen = 1'b0;
      end
      if (i_at == cyc) bus.imem_ren = 1'b0;
    end
    d_exp = eff_lat(dl) + 2;
    if (want_d) chk("dhit_cycle", d_at, d_exp);
    if (want_i) chk("ihit_cycle", i_at, want_d ? d_exp + 1 + eff_lat(il) + 2 : eff_lat(il) + 2);
  endtask

  // RAM responder plus output monitor: pops expectations as the DUT presents bus cycles and hits
  initial begin
    bus_exp_t cur;
    rsp_exp_t re;
    bit active;
    bit have;
    int cnt;
    int clat;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    active = 1'b0;
    have   = 1'b0;
    cnt    = 0;
    clat   = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        active        = 1'b0;
        have          = 1'b0;
        bus.ram_ready = 1'b0;
      end else begin
        if (bus.ihit && bus.dhit) chk("ihit_dhit_same_cycle", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        if (bus.ihit || bus.dhit) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
          end else begin
            re = rsp_q.pop_front();
            chk("hit_kind", {30'd0, bus.dhit, bus.ihit}, re.is_data ? 32'd2 : 32'd1);
            chk("bus_err", 32'(bus.bus_err), 32'(re.err));
            if (re.chk) begin
              if (re.is_data) chk("dmem_load", bus.dmem_load, re.data);
              else            chk("imem_load", bus.imem_load, re.data);
            end
          end
        end else if (bus.bus_err) begin
          chk("stray_bus_err", 32'(bus.bus_err), 32'd0);
        end

        bus.ram_ready = 1'b0;
        if (bus.ram_req) begin
          if (!active) begin
            active = 1'b1;
            cnt    = 0;
            if (lat_q.size() == 0) begin
              chk("unexpected_issue", 32'(bus.ram_req), 32'd0);
              have = 1'b0;
              clat = 0;
            end else begin
              have = 1'b1;
              clat = lat_q.pop_front();
              cur  = bus_q.pop_front();
            end
          end
          if (have) begin
            chk("ram_addr",  bus.ram_addr,       cur.addr);
            chk("ram_we",    32'(bus.ram_we),    32'(cur.we));
            chk("ram_wstrb", 32'(bus.ram_wstrb), 32'(cur.strb));
            if (cur.we) chk("ram_wdata", bus.ram_wdata, cur.wdata);
          end
          if (cnt == clat) begin
            bus.ram_ready = 1'b1;
            if (bus.ram_we) begin
              ram_mem[bus.ram_addr >> 2] = merge(ram_rd(bus.ram_addr >> 2), bus.ram_wdata, bus.ram_wstrb);
              bus.ram_rdata = $urandom;
            end else begin
              bus.ram_rdata = ram_rd(bus.ram_addr >> 2);
            end
          end else begin
            bus.ram_rdata = $urandom;
          end
          cnt++;
        end else if (active) begin
          if (have) chk("ram_req_cycles", cnt, (clat >= TO) ? TO : clat + 1);
          active = 1'b0;
          have   = 1'b0;
        end
      end
    end
  end

  initial begin
    bus_exp_t be;
    int    hits;
    int    mode;
    bit    we;
    bit    re;
    word_t da;
    word_t ia;
    nrst           = 1'b0;
    bus.imem_ren   = 1'b0;
    bus.imem_addr  = '0;
    bus.dmem_ren   = 1'b0;
    bus.dmem_wen   = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_width = '0;
    bus.dmem_store = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    ref_mem[32'h104 >> 2] = 32'h0010_0093;
    ram_mem[32'h104 >> 2] = 32'h0010_0093;
    do_txn(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 0, 1'b0, 1'b1, 32'h0000_0104, 0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0203, 3'b000, 32'hAB00_0000, 1, 1'b0, 1'b1, 32'h0000_0300, 0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_1002, 3'b001, 32'h5A5A_0000, 0, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_1000, 3'b010, 32'h1122_3344, 0, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_1001, 3'b000, 32'h0, 2, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_1004, 3'b010, 32'h0, TO, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_1008, 3'b010, 32'h0, 2, 1'b1, 1'b0, 32'h0, 0);

    // reset while the data read has been waiting three cycles
    be.addr  = 32'h0000_2000;
    be.we    = 1'b0;
    be.strb  = 4'b0000;
    be.wdata = '0;
    bus_q.push_back(be);
    lat_q.push_back(50);
    @(negedge clk);
    bus.dmem_ren   = 1'b1;
    bus.dmem_addr  = 32'h0000_2000;
    bus.dmem_width = 3'b010;
    repeat (4) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    bus.dmem_ren = 1'b0;
    bus_q.delete();
    lat_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ihit || bus.dhit) hits++;
    end
    chk("hits_after_reset", hits, 0);

    for (int t = 0; t < 200; t++) begin
      mode = $urandom_range(0, 2);
      we   = ($urandom_range(0, 1) == 1);
      re   = we ? ($urandom_range(0, 1) == 1) : 1'b1;
      da   = 32'h0000_1000 + $urandom_range(0, 63);
      ia   = 32'h0000_1000 + $urandom_range(0, 63);
      do_txn(mode != 0, we, re, da, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, TO),
             ($urandom_range(0, 3) == 0), mode != 1, ia, $urandom_range(0, TO));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", rsp_q.size() + bus_q.size() + lat_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
